// File: rtl/vga_frame_scheduler.sv
// VGA timing generator with a once-per-frame game-state update window.
// Counters and every output are registered together so sync, enable and
// blanking always describe the (column,row) currently presented.
module vga_frame_scheduler #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int SYNC_ACTIVE = 0
) (
    input  logic        vga_clock,
    input  logic        reset,
    input  logic        update_req,
    output logic [31:0] row,
    output logic [31:0] column,
    output logic        display_enable,
    output logic        hsync,
    output logic        vsync,
    output logic        vblank,
    output logic        frame_start,
    output logic [7:0]  frame_count,
    output logic        update_grant,
    output logic        update_overrun
);

    localparam logic [31:0] H_TOTAL  = 32'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
    localparam logic [31:0] V_TOTAL  = 32'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);
    localparam logic [31:0] H_VIS    = 32'(H_VISIBLE);
    localparam logic [31:0] V_VIS    = 32'(V_VISIBLE);
    localparam logic [31:0] HS_START = 32'(H_VISIBLE + H_FRONT);
    localparam logic [31:0] HS_END   = 32'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [31:0] VS_START = 32'(V_VISIBLE + V_FRONT);
    localparam logic [31:0] VS_END   = 32'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic        SYNC_ON  = (SYNC_ACTIVE != 0);

    typedef enum logic [1:0] {
        ST_ARMED   = 2'd0,
        ST_GRANTED = 2'd1,
        ST_SERVED  = 2'd2
    } state_t;

    logic [31:0] column_q, column_d;
    logic [31:0] row_q, row_d;
    logic        de_q, de_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        vblank_q, vblank_d;
    logic        fs_q, fs_d;
    logic [7:0]  fc_q, fc_d;
    state_t      state_q, state_d;
    logic        ovr_q, ovr_d;

    logic        guard_entry_d;
    logic        in_window;

    // Next raster position: column wraps every line, row advances on that wrap.
    always_comb begin
        column_d = column_q + 32'd1;
        row_d    = row_q;
        if (column_q == H_TOTAL - 32'd1) begin
            column_d = 32'd0;
            row_d    = (row_q == V_TOTAL - 32'd1) ? 32'd0 : row_q + 32'd1;
        end
    end

    // Decode the next position so registered outputs align with the counters.
    always_comb begin
        de_d     = (column_d < H_VIS) && (row_d < V_VIS);
        hsync_d  = ((column_d >= HS_START) && (column_d <= HS_END)) ? SYNC_ON : ~SYNC_ON;
        vsync_d  = ((row_d >= VS_START) && (row_d <= VS_END)) ? SYNC_ON : ~SYNC_ON;
        vblank_d = (row_d >= V_VIS);
        fs_d     = (column_d == 32'd0) && (row_d == 32'd0);
        fc_d     = fs_d ? fc_q + 8'd1 : fc_q;
    end

    // The window is judged on the current row; guard entry on the next position,
    // so a grant is dropped on the very edge that enters the guard line.
    assign in_window     = (row_q >= V_VIS) && (row_q <= V_TOTAL - 32'd2);
    assign guard_entry_d = (column_d == 32'd0) && (row_d == V_TOTAL - 32'd1);

    // Arbiter next state: one grant per frame, force-revoked at the guard line.
    always_comb begin
        state_d = state_q;
        ovr_d   = 1'b0;
        case (state_q)
            ST_ARMED: begin
                if (in_window && update_req && !guard_entry_d) begin
                    state_d = ST_GRANTED;
                end
            end
            ST_GRANTED: begin
                if (guard_entry_d) begin
                    state_d = ST_SERVED;
                    ovr_d   = update_req;
                end else if (!update_req) begin
                    state_d = ST_SERVED;
                end
            end
            ST_SERVED: begin
                state_d = ST_SERVED;
            end
            default: begin
                state_d = ST_SERVED;
            end
        endcase
        if (fs_d) begin
            state_d = ST_ARMED;
        end
    end

    // State and output registers; reset parks counters on the last pixel.
    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            column_q <= H_TOTAL - 32'd1;
            row_q    <= V_TOTAL - 32'd1;
            de_q     <= 1'b0;
            hsync_q  <= ~SYNC_ON;
            vsync_q  <= ~SYNC_ON;
            vblank_q <= 1'b1;
            fs_q     <= 1'b0;
            fc_q     <= 8'd0;
            state_q  <= ST_SERVED;
            ovr_q    <= 1'b0;
        end else begin
            column_q <= column_d;
            row_q    <= row_d;
            de_q     <= de_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            vblank_q <= vblank_d;
            fs_q     <= fs_d;
            fc_q     <= fc_d;
            state_q  <= state_d;
            ovr_q    <= ovr_d;
        end
    end

    assign column         = column_q;
    assign row            = row_q;
    assign display_enable = de_q;
    assign hsync          = hsync_q;
    assign vsync          = vsync_q;
    assign vblank         = vblank_q;
    assign frame_start    = fs_q;
    assign frame_count    = fc_q;
    assign update_grant   = (state_q == ST_GRANTED);
    assign update_overrun = ovr_q;

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Bench for vga_frame_scheduler using a reduced raster so whole frames fit
// in a short run. Two instances differ only in sync polarity.
module tb_vga_frame_scheduler;

    localparam int HV = 16, HF = 2, HS = 3, HB = 3;
    localparam int VV = 12, VF = 2, VS = 2, VB = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FR = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;

    logic [31:0] row0, col0, row1, col1;
    logic        de0, hs0, vs0, vb0, fs0, gr0, ov0;
    logic        de1, hs1, vs1, vb1, fs1, gr1, ov1;
    logic [7:0]  fc0, fc1;

    int npass = 0;
    int ntotal = 0;

    // Reference model state: absolute pixel index since reset release.
    int m_p;
    bit m_rst;
    int m_col, m_row, m_fc;
    bit m_g, m_used, m_ovr;

    always #5 clk = ~clk;

    vga_frame_scheduler #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_ACTIVE(0)
    ) dut0 (
        .vga_clock(clk), .reset(rst_n), .update_req(req),
        .row(row0), .column(col0), .display_enable(de0),
        .hsync(hs0), .vsync(vs0), .vblank(vb0), .frame_start(fs0),
        .frame_count(fc0), .update_grant(gr0), .update_overrun(ov0)
    );

    vga_frame_scheduler #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_ACTIVE(1)
    ) dut1 (
        .vga_clock(clk), .reset(rst_n), .update_req(req),
        .row(row1), .column(col1), .display_enable(de1),
        .hsync(hs1), .vsync(vs1), .vblank(vb1), .frame_start(fs1),
        .frame_count(fc1), .update_grant(gr1), .update_overrun(ov1)
    );

    function automatic bit e_de();
        return (m_col < HV) && (m_row < VV);
    endfunction

    function automatic bit e_hs(input bit sa);
        return (m_col >= HV + HF && m_col < HV + HF + HS) ? sa : !sa;
    endfunction

    function automatic bit e_vs(input bit sa);
        return (m_row >= VV + VF && m_row < VV + VF + VS) ? sa : !sa;
    endfunction

    function automatic bit e_fs();
        return !m_rst && m_col == 0 && m_row == 0;
    endfunction

    function automatic logic [81:0] exp_vec();
        return {32'(m_col), 32'(m_row), e_de(), (m_row >= VV), e_hs(1'b0), e_vs(1'b0),
                e_hs(1'b1), e_vs(1'b1), e_fs(), 8'(m_fc)};
    endfunction

    function automatic logic [81:0] got_vec();
        return {col0, row0, de0, vb0, hs0, vs0, hs1, vs1, fs0, fc0};
    endfunction

    task automatic model_reset();
        m_rst = 1'b1;
        m_col = HT - 1;
        m_row = VT - 1;
        m_fc  = 0;
        m_g   = 1'b0;
        m_used = 1'b1;
        m_ovr = 1'b0;
    endtask

    // Advance one clock and apply the arbitration rules to the model.
    task automatic step();
        bit rq;
        int pr;
        bit guard, wrap;
        rq = req;
        pr = m_row;
        @(posedge clk);
        if (rst_n) begin
            if (m_rst) begin
                m_rst = 1'b0;
                m_p = 0;
            end else begin
                m_p++;
            end
            m_col = m_p % HT;
            m_row = (m_p / HT) % VT;
            m_fc  = (m_p / FR + 1) % 256;
            guard = (m_col == 0 && m_row == VT - 1);
            wrap  = (m_col == 0 && m_row == 0);
            m_ovr = 1'b0;
            if (wrap) begin
                m_g = 1'b0;
                m_used = 1'b0;
            end else if (m_g) begin
                if (guard) begin
                    m_ovr = rq;
                    m_g = 1'b0;
                end else if (!rq) begin
                    m_g = 1'b0;
                end
            end else if (!m_used && rq && pr >= VV && pr <= VT - 2 && !guard) begin
                m_g = 1'b1;
                m_used = 1'b1;
            end
        end
        #1;
    endtask

    task automatic run_to(input int c, input int r);
        for (int i = 0; i < FR + 2; i++) begin
            if (m_col == c && m_row == r) break;
            step();
        end
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) step();
        ntotal++;
        if ({got_vec(), gr0, ov0} !== {exp_vec(), 2'b00})
            $display("FAIL reset_values got=%h exp=%h", {got_vec(), gr0, ov0}, {exp_vec(), 2'b00});
        else npass++;
        rst_n = 1'b1;
        step();
        ntotal++;
        if ({col0, row0, de0, fs0, fc0} !== {32'd0, 32'd0, 1'b1, 1'b1, 8'd1})
            $display("FAIL first_edge got col=%0d row=%0d de=%b fs=%b fc=%0d exp 0 0 1 1 1",
                     col0, row0, de0, fs0, fc0);
        else npass++;
        $display("test_reset done");
    endtask

    task automatic test_counters();
        int n_de, n_hs, n_vs, n_fs;
        for (int f = 0; f < 2; f++) begin
            run_to(0, 0);
            n_de = 0; n_hs = 0; n_vs = 0; n_fs = 0;
            for (int i = 0; i < FR; i++) begin
                ntotal++;
                if (got_vec() !== exp_vec()) begin
                    $display("FAIL raster p=%0d got=%h exp=%h", m_p, got_vec(), exp_vec());
                end else npass++;
                n_de += int'(de0);
                n_hs += int'(!hs0);
                n_vs += int'(!vs0);
                n_fs += int'(fs0);
                req = ($urandom_range(0, 7) == 0);
                step();
            end
            ntotal++;
            if (n_de !== HV * VV) $display("FAIL de_count got=%0d exp=%0d", n_de, HV * VV);
            else npass++;
            ntotal++;
            if (n_hs !== HS * VT) $display("FAIL hsync_count got=%0d exp=%0d", n_hs, HS * VT);
            else npass++;
            ntotal++;
            if (n_vs !== VS * HT) $display("FAIL vsync_count got=%0d exp=%0d", n_vs, VS * HT);
            else npass++;
            ntotal++;
            if (n_fs !== 1) $display("FAIL frame_start_count got=%0d exp=1", n_fs);
            else npass++;
            $display("test_counters frame %0d de=%0d hs=%0d vs=%0d fs=%0d", f, n_de, n_hs, n_vs, n_fs);
        end
        req = 1'b0;
    endtask

    task automatic test_normal_grant();
        int early;
        req = 1'b0;
        run_to(0, 0);
        run_to(0, 2);
        req = 1'b1;
        early = 0;
        for (int i = 0; i < FR; i++) begin
            if (m_col == 0 && m_row == VV) break;
            early += int'(gr0);
            step();
        end
        ntotal++;
        if (early !== 0 || gr0 !== 1'b0)
            $display("FAIL grant_early got=%0d/%b exp=0/0", early, gr0);
        else npass++;
        step();
        ntotal++;
        if (gr0 !== 1'b1 || m_col != 1 || m_row != VV)
            $display("FAIL grant_rise got=%b at (%0d,%0d) exp=1 at (1,%0d)", gr0, m_col, m_row, VV);
        else npass++;
        repeat (5) step();
        req = 1'b0;
        step();
        ntotal++;
        if ({gr0, ov0} !== 2'b00) $display("FAIL grant_release got=%b%b exp=00", gr0, ov0);
        else npass++;
        req = 1'b1;
        early = 0;
        for (int i = 0; i < FR; i++) begin
            if (m_col == 0 && m_row == 0) break;
            early += int'(gr0) + int'(ov0);
            step();
        end
        ntotal++;
        if (early !== 0) $display("FAIL no_regrant got=%0d exp=0", early);
        else npass++;
        $display("test_normal_grant done");
    endtask

    task automatic test_overrun();
        int rise_pos, ovr_pos, n_ovr;
        bit prev_g;
        req = 1'b1;
        run_to(0, 0);
        rise_pos = -1; ovr_pos = -1; n_ovr = 0; prev_g = 1'b0;
        for (int i = 0; i < FR; i++) begin
            if (gr0 && !prev_g) rise_pos = m_p % FR;
            if (ov0) begin
                n_ovr++;
                ovr_pos = m_p % FR;
                ntotal++;
                if (gr0 !== 1'b0) $display("FAIL overrun_grant got=%b exp=0", gr0);
                else npass++;
            end
            prev_g = gr0;
            step();
        end
        ntotal++;
        if (rise_pos !== VV * HT + 1) $display("FAIL overrun_rise got=%0d exp=%0d", rise_pos, VV * HT + 1);
        else npass++;
        ntotal++;
        if (ovr_pos !== (VT - 1) * HT || n_ovr !== 1)
            $display("FAIL overrun_pulse got pos=%0d n=%0d exp pos=%0d n=1", ovr_pos, n_ovr, (VT - 1) * HT);
        else npass++;
        run_to(1, VV);
        ntotal++;
        if (gr0 !== 1'b1) $display("FAIL regrant_next_frame got=%b exp=1", gr0);
        else npass++;
        $display("test_overrun rise=%0d ovr=%0d n=%0d", rise_pos, ovr_pos, n_ovr);
    endtask

    task automatic test_guard();
        int bad;
        // Request first raised once the guard line is already showing.
        req = 1'b0;
        run_to(0, 0);
        run_to(0, VT - 1);
        req = 1'b1;
        bad = 0;
        for (int i = 0; i < HT; i++) begin
            bad += int'(gr0) + int'(ov0);
            step();
        end
        ntotal++;
        if (bad !== 0) $display("FAIL guard_rise_late got=%0d exp=0", bad);
        else npass++;
        // Request dropped on the cycle that the guard line begins.
        run_to(1, VV);
        run_to(HT - 1, VT - 2);
        ntotal++;
        if (gr0 !== 1'b1) $display("FAIL guard_pre_drop got=%b exp=1", gr0);
        else npass++;
        req = 1'b0;
        step();
        ntotal++;
        if ({gr0, ov0} !== 2'b00) $display("FAIL guard_drop got=%b%b exp=00", gr0, ov0);
        else npass++;
        // Request rising on the very edge that enters the guard line.
        run_to(0, 0);
        run_to(HT - 1, VT - 2);
        req = 1'b1;
        bad = 0;
        for (int i = 0; i < HT; i++) begin
            step();
            bad += int'(gr0) + int'(ov0);
        end
        ntotal++;
        if (bad !== 0) $display("FAIL guard_rise_edge got=%0d exp=0", bad);
        else npass++;
        req = 1'b0;
        $display("test_guard done");
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 4 * FR; i++) begin
            if ($urandom_range(0, 15) == 0) req = !req;
            step();
            ntotal++;
            if ({gr0, ov0, gr1, ov1} !== {m_g, m_ovr, m_g, m_ovr}) begin
                if (errs < 10)
                    $display("FAIL random_arb p=%0d got=%b%b%b%b exp=%b%b", m_p, gr0, ov0, gr1, ov1, m_g, m_ovr);
                errs++;
            end else npass++;
        end
        $display("test_random done errs=%0d", errs);
    endtask

    task automatic test_midgrant_reset();
        req = 1'b1;
        run_to(0, 0);
        run_to(5, VV + 3);
        ntotal++;
        if (gr0 !== 1'b1) $display("FAIL midreset_pre got=%b exp=1", gr0);
        else npass++;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        ntotal++;
        if ({got_vec(), gr0, ov0} !== {exp_vec(), 2'b00})
            $display("FAIL midreset_async got=%h exp=%h", {got_vec(), gr0, ov0}, {exp_vec(), 2'b00});
        else npass++;
        repeat (3) step();
        ntotal++;
        if ({got_vec(), gr0, ov0} !== {exp_vec(), 2'b00})
            $display("FAIL midreset_hold got=%h exp=%h", {got_vec(), gr0, ov0}, {exp_vec(), 2'b00});
        else npass++;
        rst_n = 1'b1;
        step();
        ntotal++;
        if ({col0, row0, fs0, fc0, gr0, ov0} !== {32'd0, 32'd0, 1'b1, 8'd1, 2'b00})
            $display("FAIL midreset_release got col=%0d row=%0d fs=%b fc=%0d gr=%b ov=%b exp 0 0 1 1 0 0",
                     col0, row0, fs0, fc0, gr0, ov0);
        else npass++;
        req = 1'b0;
        $display("test_midgrant_reset done");
    endtask

    initial begin
        test_reset();
        test_counters();
        test_normal_grant();
        test_overrun();
        test_guard();
        test_random();
        test_midgrant_reset();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/vga_frame_scheduler.md
# vga_frame_scheduler

Sequences the VGA pixel pipeline: generates the horizontal/vertical counters, sync pulses and `display_enable` that drive the interface's `row`, `column` and blanking inputs, and arbitrates one game-state update window per frame during vertical blanking. Game logic raises `update_req` and may change Mario/Goomba positions, the countdown number and the background array only while `update_grant` is high. This keeps the drawer from tearing.

## Interface
- `H_VISIBLE`, 640, active pixels per line
- `H_FRONT`, 16, horizontal front porch (clocks)
- `H_SYNC`, 96, hsync width (clocks)
- `H_BACK`, 48, horizontal back porch (clocks)
- `V_VISIBLE`, 480, active lines per frame
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BACK`, 33, vertical back porch (lines)
- `SYNC_ACTIVE`, 0, active level of `hsync`/`vsync`
- `vga_clock`  input  1  pixel clock; all state on rising edge
- `reset`  input  1  asynchronous, active-low
- `update_req`  input  1  level request from game logic for the update window
- `row`  output  32 (int)  vertical counter, 0..V_TOTAL-1
- `column`  output  32 (int)  horizontal counter, 0..H_TOTAL-1
- `display_enable`  output  1  high iff column < H_VISIBLE and row < V_VISIBLE
- `hsync`  output  1  horizontal sync
- `vsync`  output  1  vertical sync
- `vblank`  output  1  high iff row >= V_VISIBLE
- `frame_start`  output  1  one-cycle pulse when counters are (0,0)
- `frame_count`  output  8  frames started since reset, wraps
- `update_grant`  output  1  game state may be written while high
- `update_overrun`  output  1  one-cycle pulse when grant is force-revoked with req still high

## Operation
- H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800). V_TOTAL = sum of V_* (525).
- `column` increments every clock and wraps H_TOTAL-1 -> 0. `row` increments on that wrap and itself wraps V_TOTAL-1 -> 0.
- hsync is active for column in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] (656..751). vsync is active for row in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] (490..491).
- `frame_count` increments on the edge where the counters wrap to (0,0). It wraps 255 -> 0.
- The update window spans row V_VISIBLE col 0 through the end of row V_TOTAL-2. Row V_TOTAL-1 is a guard line, and no grant is held in it.
- Arbiter FSM:
  - ARMED: if in window and update_req = 1, go to GRANTED.
  - GRANTED: if update_req = 0, go to SERVED. On entry to the guard line (row V_TOTAL-1, col 0), go to SERVED and pulse update_overrun if update_req = 1.
  - SERVED: go to ARMED at frame_start.
  - Also go to ARMED from any state at frame_start. GRANTED cannot reach frame_start, by construction.
- `update_grant` = (state == GRANTED). At most one grant per frame. A request that is still high after SERVED is not re-granted until the next frame's window.
- Simultaneous events:
  - A request rising in the same cycle that the guard line begins is not granted.
  - A request dropping in the same cycle as guard-line entry gives SERVED with no overrun.
  - A request held high from active video is granted at the window's first cycle.

## Timing
- Counters and all outputs are registered and update on the same edge. sync, enable and vblank always describe the current (column,row) with zero skew.
- Reset values (held while reset = 0):
  - column = H_TOTAL-1, row = V_TOTAL-1
  - display_enable = 0, vblank = 1, hsync = vsync = !SYNC_ACTIVE
  - frame_start = 0, frame_count = 0
  - update_grant = 0, update_overrun = 0
  - FSM = SERVED
- First rising edge after reset release: column = 0, row = 0, display_enable = 1, frame_start = 1, frame_count = 1.
- Grant latency is one clock. If update_req is sampled high in ARMED inside the window at edge n, update_grant = 1 after edge n+1. The edge that counts is the one that sets (col 0, row 480), not the edge where the counters still read (799, 479).
- Release latency is one clock. update_req sampled low at edge n gives update_grant = 0 after edge n+1.
- Forced revoke: update_grant falls on the edge that sets (0, V_TOTAL-1). update_overrun is high for that one cycle only.
- Reset asserted mid-frame or mid-grant: all outputs go to reset values immediately (asynchronously). No overrun pulse is issued.

## Test plan
- **Reset release:** release, count 420000 clocks. Require:
  - frame_start once every 420000 clocks; first at the first edge.
  - frame_count = 1 after the first edge, then +1 per frame.
  - display_enable high for exactly 307200 clocks per frame.
- **Sync placement:** hsync = SYNC_ACTIVE only at columns 656..751 (96 clocks per line). vsync = SYNC_ACTIVE only on rows 490..491 (1600 clocks). Repeat with SYNC_ACTIVE = 1 for inverted levels.
- **Normal grant:** update_req = 1 from row 100, then dropped 50 clocks into the grant. Require:
  - grant rises one clock after (0,480) is set;
  - grant falls one clock after req low;
  - no second grant that frame even though req is re-raised.
- **Overrun:** update_req = 1 held through the whole frame. Require:
  - grant falls on the edge setting (0,524), with update_overrun high exactly 1 cycle;
  - grant again in the next frame at (0,480).
- **Guard-line edge cases:** req first raised at (0,524) gives no grant that frame. req dropped on the cycle of guard-line entry gives no overrun pulse.
- **Mid-grant reset:** assert reset while update_grant = 1 at row 500. All outputs take reset values within the same cycle. After release, frame_start occurs at the first edge and frame_count = 1.
